// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin arbiter sharing one D$-to-LCE cache request channel between the
// D$ miss path (requester 0) and the PTW / uncached path (requester 1).
module bp_be_cache_req_arbiter #(
  parameter int req_width_p      = 128,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [req_width_p-1:0]      req0_i,
  input  logic                        req0_v_i,
  output logic                        req0_ready_o,
  input  logic [metadata_width_p-1:0] req0_metadata_i,
  input  logic                        req0_metadata_v_i,
  output logic                        req0_complete_o,

  input  logic [req_width_p-1:0]      req1_i,
  input  logic                        req1_v_i,
  output logic                        req1_ready_o,
  input  logic [metadata_width_p-1:0] req1_metadata_i,
  input  logic                        req1_metadata_v_i,
  output logic                        req1_complete_o,

  output logic [req_width_p-1:0]      cache_req_o,
  output logic                        cache_req_v_o,
  input  logic                        cache_req_ready_i,
  output logic [metadata_width_p-1:0] cache_req_metadata_o,
  output logic                        cache_req_metadata_v_o,
  input  logic                        cache_req_complete_i,
  input  logic                        cache_req_credits_full_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e state_r, state_next;
  logic   owner_r, owner_next;
  logic   last_r, last_next;

  // Requester-indexed views so the owner/selection muxes are plain array reads.
  logic [1:0]                  req_v;
  logic [1:0]                  req_md_v;
  logic [req_width_p-1:0]      req_pkt [2];
  logic [metadata_width_p-1:0] req_md  [2];
  logic [1:0]                  ready_vec;
  logic [1:0]                  complete_vec;

  assign req_v      = {req1_v_i, req0_v_i};
  assign req_md_v   = {req1_metadata_v_i, req0_metadata_v_i};
  assign req_pkt[0] = req0_i;
  assign req_pkt[1] = req1_i;
  assign req_md[0]  = req0_metadata_i;
  assign req_md[1]  = req1_metadata_i;

  logic sel;
  logic handshake;
  logic complete_fire;

  // On a tie the requester that did not win last time gets the channel.
  assign sel = (&req_v) ? ~last_r : req_v[1];

  always_comb begin
    state_next             = state_r;
    owner_next             = owner_r;
    last_next              = last_r;
    cache_req_v_o          = 1'b0;
    cache_req_o            = '0;
    cache_req_metadata_o   = '0;
    cache_req_metadata_v_o = 1'b0;
    handshake              = 1'b0;
    complete_fire          = 1'b0;

    unique case (state_r)
      IDLE: begin
        cache_req_v_o = (|req_v) & ~cache_req_credits_full_i;
        cache_req_o   = (|req_v) ? req_pkt[sel] : '0;
        handshake     = cache_req_v_o & cache_req_ready_i;
        if (handshake) begin
          state_next = META;
          owner_next = sel;
          last_next  = sel;
        end
      end
      META: begin
        cache_req_metadata_o   = req_md[owner_r];
        cache_req_metadata_v_o = req_md_v[owner_r];
        complete_fire          = cache_req_complete_i;
        // Completion wins over metadata when both land in the same cycle.
        if (cache_req_complete_i) begin
          state_next = IDLE;
        end else if (req_md_v[owner_r]) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        complete_fire = cache_req_complete_i;
        if (cache_req_complete_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready_vec[gi]    = handshake & (sel == 1'(gi));
      assign complete_vec[gi] = complete_fire & (owner_r == 1'(gi));
    end
  endgenerate

  assign req0_ready_o    = ready_vec[0];
  assign req1_ready_o    = ready_vec[1];
  assign req0_complete_o = complete_vec[0];
  assign req1_complete_o = complete_vec[1];

  // last_r resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_next;
      owner_r <= owner_next;
      last_r  <= last_next;
    end
  end

  // A completion with nothing outstanding means the LCE and BE disagree.
  complete_in_idle_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !((state_r == IDLE) && cache_req_complete_i));

  only_one_ready_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(req0_ready_o && req1_ready_o));

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Self-checking bench for bp_be_cache_req_arbiter: directed scenarios plus
// randomized traffic, compared every cycle against a transaction-level model.
module tb_bp_be_cache_req_arbiter;
  localparam int RW = 128;
  localparam int MW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [RW-1:0] req0_i, req1_i;
  logic          req0_v_i, req1_v_i;
  logic          req0_ready_o, req1_ready_o;
  logic [MW-1:0] req0_metadata_i, req1_metadata_i;
  logic          req0_metadata_v_i, req1_metadata_v_i;
  logic          req0_complete_o, req1_complete_o;
  logic [RW-1:0] cache_req_o;
  logic          cache_req_v_o;
  logic          cache_req_ready_i;
  logic [MW-1:0] cache_req_metadata_o;
  logic          cache_req_metadata_v_o;
  logic          cache_req_complete_i;
  logic          cache_req_credits_full_i;

  always #5 clk_i = ~clk_i;

  bp_be_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_i(req0_i), .req0_v_i(req0_v_i), .req0_ready_o(req0_ready_o),
    .req0_metadata_i(req0_metadata_i), .req0_metadata_v_i(req0_metadata_v_i),
    .req0_complete_o(req0_complete_o),
    .req1_i(req1_i), .req1_v_i(req1_v_i), .req1_ready_o(req1_ready_o),
    .req1_metadata_i(req1_metadata_i), .req1_metadata_v_i(req1_metadata_v_i),
    .req1_complete_o(req1_complete_o),
    .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_ready_i(cache_req_ready_i),
    .cache_req_metadata_o(cache_req_metadata_o),
    .cache_req_metadata_v_o(cache_req_metadata_v_o),
    .cache_req_complete_i(cache_req_complete_i),
    .cache_req_credits_full_i(cache_req_credits_full_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: is the channel held, has the owner sent metadata,
  // who owns it, and who won last.
  bit m_locked, m_meta_done, m_owner, m_last;
  int grant_log[$];
  int txn_cnt = 0;
  bit m_r0, m_r1;
  logic obs_r0, obs_r1, obs_c0, obs_c1;

  function automatic logic [RW-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_inputs();
    req0_v_i = 0; req1_v_i = 0; req0_i = '0; req1_i = '0;
    req0_metadata_i = '0; req1_metadata_i = '0;
    req0_metadata_v_i = 0; req1_metadata_v_i = 0;
    cache_req_ready_i = 0; cache_req_complete_i = 0; cache_req_credits_full_i = 0;
  endtask

  // One clock: sample outputs mid-cycle, compare, advance the model, cross the edge.
  task automatic step();
    bit anyv, sel, e_v, e_r0, e_r1, e_mdv, e_c0, e_c1;
    logic [RW-1:0] e_pkt;
    logic [MW-1:0] e_md;
    #2;
    anyv  = req0_v_i | req1_v_i;
    sel   = (req0_v_i && req1_v_i) ? !m_last : req1_v_i;
    e_v = 0; e_r0 = 0; e_r1 = 0; e_mdv = 0; e_c0 = 0; e_c1 = 0;
    e_pkt = '0; e_md = '0;
    if (!m_locked) begin
      e_v   = anyv && !cache_req_credits_full_i;
      e_pkt = anyv ? (sel ? req1_i : req0_i) : '0;
      e_r0  = e_v && cache_req_ready_i && !sel;
      e_r1  = e_v && cache_req_ready_i && sel;
    end else begin
      if (!m_meta_done) begin
        e_md  = m_owner ? req1_metadata_i : req0_metadata_i;
        e_mdv = m_owner ? req1_metadata_v_i : req0_metadata_v_i;
      end
      e_c0 = cache_req_complete_i && !m_owner;
      e_c1 = cache_req_complete_i && m_owner;
    end
    obs_r0 = req0_ready_o; obs_r1 = req1_ready_o;
    obs_c0 = req0_complete_o; obs_c1 = req1_complete_o;
    if (!reset_i) begin
      check_val("cache_req_v", cache_req_v_o, e_v);
      check_val("cache_req", cache_req_o, e_pkt);
      check_val("req0_ready", req0_ready_o, e_r0);
      check_val("req1_ready", req1_ready_o, e_r1);
      check_val("meta_v", cache_req_metadata_v_o, e_mdv);
      if (e_mdv) check_val("meta", cache_req_metadata_o, e_md);
      check_val("req0_complete", req0_complete_o, e_c0);
      check_val("req1_complete", req1_complete_o, e_c1);
    end
    m_r0 = e_r0 && !reset_i;
    m_r1 = e_r1 && !reset_i;
    if (reset_i) begin
      m_locked = 0; m_meta_done = 0; m_owner = 0; m_last = 1;
    end else if (!m_locked) begin
      if (e_v && cache_req_ready_i) begin
        m_locked = 1; m_meta_done = 0; m_owner = sel; m_last = sel;
        grant_log.push_back(int'(sel));
      end
    end else if (cache_req_complete_i) begin
      txn_cnt++;
      $display("txn %0d: requester %0d completed", txn_cnt, m_owner);
      m_locked = 0;
    end else if (!m_meta_done && e_mdv) begin
      m_meta_done = 1;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Well-behaved owner/LCE: metadata the cycle after grant, then complete.
  task automatic lce_drive();
    cache_req_complete_i = 0;
    req0_metadata_v_i = 0; req1_metadata_v_i = 0;
    if (m_locked) begin
      if (!m_meta_done) begin
        if (m_owner) begin req1_metadata_v_i = 1; req1_metadata_i = MW'($urandom()); end
        else begin req0_metadata_v_i = 1; req0_metadata_i = MW'($urandom()); end
      end else begin
        cache_req_complete_i = 1;
      end
    end
  endtask

  task automatic drain(input string tag);
    req0_v_i = 0; req1_v_i = 0;
    for (int k = 0; k < 20 && m_locked; k++) begin
      lce_drive();
      step();
    end
    check_val(tag, m_locked, 0);
    cache_req_complete_i = 0; req0_metadata_v_i = 0; req1_metadata_v_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1;
    step();
    step();
    reset_i = 0;
  endtask

  initial begin
    bit h0, h1;
    clear_inputs();
    reset_i = 1;
    @(posedge clk_i);
    #1;
    do_reset();
    step();

    // Single requester 0 transaction with 0xA5.
    req0_v_i = 1; req0_i = RW'(8'hA5); cache_req_ready_i = 1;
    step();
    check_val("t1_ready0", obs_r0, 1);
    req0_v_i = 0; req0_metadata_i = 8'h3; req0_metadata_v_i = 1;
    step();
    req0_metadata_v_i = 0;
    step();
    cache_req_complete_i = 1;
    step();
    check_val("t1_complete0", obs_c0, 1);
    check_val("t1_complete1", obs_c1, 0);
    cache_req_complete_i = 0;
    step();

    // Both held valid from reset: strict alternation.
    do_reset();
    grant_log.delete();
    cache_req_ready_i = 1;
    req0_v_i = 1; req1_v_i = 1; req0_i = rand_pkt(); req1_i = rand_pkt();
    for (int k = 0; k < 80 && grant_log.size() < 6; k++) begin
      lce_drive();
      step();
      if (m_r0) req0_i = rand_pkt();
      if (m_r1) req1_i = rand_pkt();
    end
    check_val("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check_val("rr_order", grant_log[i], i % 2);
    drain("rr_drain");

    // Credits full blocks requester 1, release grants the same cycle.
    cache_req_credits_full_i = 1; req1_v_i = 1; req1_i = rand_pkt(); cache_req_ready_i = 1;
    repeat (5) begin
      step();
      check_val("cred_blocked", obs_r1, 0);
    end
    cache_req_credits_full_i = 0;
    step();
    check_val("cred_grant", obs_r1, 1);
    drain("cred_drain");

    // Make requester 0 the last winner, then stall ready with req1 waiting.
    req0_v_i = 1; req0_i = rand_pkt();
    step();
    drain("r0_drain");
    req1_v_i = 1; req1_i = rand_pkt(); cache_req_ready_i = 0;
    step();
    req0_v_i = 1; req0_i = rand_pkt();
    step();
    step();
    cache_req_ready_i = 1;
    step();
    check_val("stall_r1", obs_r1, 1);
    check_val("stall_r0", obs_r0, 0);
    drain("stall_drain");

    // Reset while requester 1 is in WAIT.
    req1_v_i = 1; req1_i = rand_pkt();
    step();
    req1_v_i = 0; req1_metadata_v_i = 1; req1_metadata_i = 8'h5A;
    step();
    req1_metadata_v_i = 0;
    step();
    reset_i = 1;
    step();
    reset_i = 0; clear_inputs();
    step();
    check_val("rst_c1", obs_c1, 0);
    req0_v_i = 1; req1_v_i = 1; cache_req_ready_i = 1;
    req0_i = rand_pkt(); req1_i = rand_pkt();
    step();
    check_val("rst_first_r0", obs_r0, 1);
    check_val("rst_first_r1", obs_r1, 0);
    drain("rst_drain");

    // Random traffic honouring the valid-hold and completion rules.
    h0 = 0; h1 = 0;
    for (int c = 0; c < 1500; c++) begin
      reset_i = ($urandom_range(199) == 0);
      if (!h0) begin
        req0_v_i = ($urandom_range(2) != 0); req0_i = rand_pkt(); h0 = req0_v_i;
      end else if ($urandom_range(15) == 0) begin
        req0_v_i = 0; h0 = 0;
      end
      if (!h1) begin
        req1_v_i = ($urandom_range(2) != 0); req1_i = rand_pkt(); h1 = req1_v_i;
      end else if ($urandom_range(15) == 0) begin
        req1_v_i = 0; h1 = 0;
      end
      cache_req_ready_i        = ($urandom_range(3) != 0);
      cache_req_credits_full_i = ($urandom_range(4) == 0);
      req0_metadata_i   = MW'($urandom()); req1_metadata_i = MW'($urandom());
      req0_metadata_v_i = $urandom_range(1); req1_metadata_v_i = $urandom_range(1);
      cache_req_complete_i = m_locked && !reset_i && ($urandom_range(2) == 0);
      step();
      if (m_r0) h0 = 0;
      if (m_r1) h1 = 0;
    end
    reset_i = 0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
